// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed 8-digit BCD display: digit count,
// active-low segment patterns ({g,f,e,d,c,b,a}) and parameter legality limits.
package bcd_scan_display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SCAN_DIV_MIN  = 4;
  localparam int SCAN_DIV_MAX  = 1 << 20;
  localparam int BLANK_CYC_MIN = 1;

endpackage

// File: rtl/bcd_scan_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show 'E'.
module bcd_to_seg7
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_E;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 8-digit BCD display driver with frame-coherent input
// snapshot, leading-zero blanking, decimal point and anode ghosting guard.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [3:0] d7,
  input  logic       lzb_en,
  input  logic       dp_en,
  input  logic [2:0] dp_pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame
);

  localparam int PW = $clog2(SCAN_DIV);

  if (SCAN_DIV < SCAN_DIV_MIN || SCAN_DIV > SCAN_DIV_MAX ||
      BLANK_CYC < BLANK_CYC_MIN || BLANK_CYC > SCAN_DIV - 2) begin : g_bad_params
    $error("bcd_scan_display: illegal SCAN_DIV/BLANK_CYC");
  end

  logic [PW-1:0]                  r_presc;
  logic [2:0]                     r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_snap_d;
  logic                           r_snap_lzb;
  logic                           r_snap_dpen;
  logic [2:0]                     r_snap_dppos;
  logic [7:0]                     r_an;
  logic [6:0]                     r_seg;
  logic                           r_dp_n;
  logic                           r_frame;

  logic [NUM_DIGITS-1:0][3:0]     w_d_in;
  logic                           w_wrap;
  logic                           w_capture;
  logic                           w_upper_zero;
  logic                           w_blank;
  logic                           w_active;
  logic [6:0]                     w_seg_dec;
  logic [7:0]                     w_an_nxt;
  logic [6:0]                     w_seg_nxt;
  logic                           w_dp_n_nxt;

  assign w_d_in    = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign w_wrap    = (r_presc == PW'(SCAN_DIV - 1));
  assign w_capture = (r_presc == '0) && (r_idx == 3'd0);

  // Blanking looks at the current digit and everything above it.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) >= r_idx && r_snap_d[i] != 4'd0) w_upper_zero = 1'b0;
    end
  end

  assign w_blank  = r_snap_lzb && (r_idx != 3'd0) && w_upper_zero &&
                    !(r_snap_dpen && (r_snap_dppos >= r_idx));
  assign w_active = (r_presc >= PW'(BLANK_CYC)) && !w_blank;

  bcd_to_seg7 u_dec (
    .i_bcd (r_snap_d[r_idx]),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_an_nxt   = 8'hFF;
    w_seg_nxt  = SEG_BLANK;
    w_dp_n_nxt = 1'b1;
    if (w_active) begin
      w_an_nxt   = ~(8'd1 << r_idx);
      w_seg_nxt  = w_seg_dec;
      w_dp_n_nxt = !(r_snap_dpen && (r_snap_dppos == r_idx));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= 3'd0;
      r_snap_d     <= '0;
      r_snap_lzb   <= 1'b0;
      r_snap_dpen  <= 1'b0;
      r_snap_dppos <= 3'd0;
      r_an         <= 8'hFF;
      r_seg        <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_frame      <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) r_idx <= r_idx + 3'd1;
      if (w_capture) begin
        r_snap_d     <= w_d_in;
        r_snap_lzb   <= lzb_en;
        r_snap_dpen  <= dp_en;
        r_snap_dppos <= dp_pos;
      end
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp_n  <= w_dp_n_nxt;
      r_frame <= w_capture;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp_n  = r_dp_n;
  assign frame = r_frame;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed and randomized bench for bcd_scan_display against a cycle-count
// based reference model of the scan, snapshot and blanking rules.
module tb_bcd_scan_display;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME_LEN = SD * 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] td [8];
  logic       lzb_en, dp_en;
  logic [2:0] dp_pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp_n, frame;

  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;

  // Model snapshot
  int  m_d [8];
  bit  m_lzb, m_dpen;
  int  m_dppos;

  byte seg_tab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                        8'h00, 8'h10, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06};

  always #5 clk = ~clk;

  bcd_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d0     (td[0]),
    .d1     (td[1]),
    .d2     (td[2]),
    .d3     (td[3]),
    .d4     (td[4]),
    .d5     (td[5]),
    .d6     (td[6]),
    .d7     (td[7]),
    .lzb_en (lzb_en),
    .dp_en  (dp_en),
    .dp_pos (dp_pos),
    .an     (an),
    .seg    (seg),
    .dp_n   (dp_n),
    .frame  (frame)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s (cycle %0d): got %02h expected %02h", tag, n, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_d[i] = 0;
    m_lzb = 0; m_dpen = 0; m_dppos = 0;
  endtask

  // Expected outputs for a cycle where the scan sits at (presc, slot).
  task automatic model_out(input int presc, input int slot,
                           output logic [7:0] e_an, output logic [7:0] e_seg,
                           output logic [7:0] e_dp);
    bit upper_zero, blanked;
    upper_zero = 1;
    for (int j = slot; j < 8; j++) if (m_d[j] != 0) upper_zero = 0;
    blanked = m_lzb && slot > 0 && upper_zero && !(m_dpen && m_dppos >= slot);
    if (presc >= BC && !blanked) begin
      e_an  = 8'hFF ^ (8'(1) << slot);
      e_seg = seg_tab[m_d[slot]];
      e_dp  = (m_dpen && m_dppos == slot) ? 8'd0 : 8'd1;
    end else begin
      e_an  = 8'hFF;
      e_seg = 8'h7F;
      e_dp  = 8'd1;
    end
  endtask

  task automatic step();
    logic [7:0] e_an, e_seg, e_dp, e_fr;
    model_out(n % SD, (n / SD) % 8, e_an, e_seg, e_dp);
    e_fr = (n % FRAME_LEN == 0) ? 8'd1 : 8'd0;
    if (n % FRAME_LEN == 0) begin
      for (int i = 0; i < 8; i++) m_d[i] = int'(td[i]);
      m_lzb = lzb_en; m_dpen = dp_en; m_dppos = int'(dp_pos);
    end
    @(posedge clk); #1;
    chk("an", an, e_an);
    chk("seg", {1'b0, seg}, e_seg);
    chk("dp_n", {7'd0, dp_n}, e_dp);
    chk("frame", {7'd0, frame}, e_fr);
    n++;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic set_digits(input int v7, input int v6, input int v5, input int v4,
                            input int v3, input int v2, input int v1, input int v0);
    td[7] = 4'(v7); td[6] = 4'(v6); td[5] = 4'(v5); td[4] = 4'(v4);
    td[3] = 4'(v3); td[2] = 4'(v2); td[1] = 4'(v1); td[0] = 4'(v0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    chk({tag, "_dp_n"}, {7'd0, dp_n}, 8'd1);
    chk({tag, "_frame"}, {7'd0, frame}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    set_digits(0, 0, 0, 0, 0, 0, 0, 0);
    lzb_en = 1'b1; dp_en = 1'b0; dp_pos = 3'd0;
    #1 rst_n = 1'b0;
    #2 check_reset_vals("rst");
    @(posedge clk); #1;
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    n = 0;
    model_clear();

    // All-zero value with blanking: only digit 0 lights
    run(80);

    // 00123456 with blanking
    set_digits(0, 0, 1, 2, 3, 4, 5, 6);
    run(128);

    // "0.000" via decimal point protecting digits 1..3
    set_digits(0, 0, 0, 0, 0, 0, 0, 0);
    dp_en = 1'b1; dp_pos = 3'd3;
    run(128);

    // Out-of-range code on digit 0
    dp_en = 1'b0; dp_pos = 3'd0;
    set_digits(0, 0, 0, 0, 0, 0, 0, 12);
    run(64);

    // Out-of-range code counts as nonzero for blanking
    set_digits(0, 0, 0, 11, 0, 0, 0, 0);
    run(64);

    // Change inputs mid-frame at slot 3; snapshot must hold until next frame
    set_digits(9, 8, 7, 6, 5, 4, 3, 2);
    lzb_en = 1'b0;
    while ((n % FRAME_LEN) != 3 * SD + 1) step();
    set_digits(1, 1, 1, 1, 1, 1, 1, 1);
    dp_en = 1'b1; dp_pos = 3'd6;
    run(100);

    // Randomized inputs changing at arbitrary times
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < 8; i++)
          td[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        lzb_en = 1'($urandom_range(0, 3) != 0);
        dp_en  = 1'($urandom_range(0, 1));
        dp_pos = 3'($urandom_range(0, 7));
      end
      step();
    end

    // Asynchronous reset at slot 5, prescaler 4, then restart from slot 0
    set_digits(0, 0, 0, 0, 8, 8, 8, 8);
    lzb_en = 1'b1; dp_en = 1'b0;
    while ((n % FRAME_LEN) != 5 * SD + 4) step();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(posedge clk); #1;
    check_reset_vals("async_rst_held");
    rst_n = 1'b1;
    n = 0;
    model_clear();
    run(96);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
